// File: rtl/alarm_pkg.sv
// Shared types and minute-of-day helpers for the alarm sequencer.
package alarm_pkg;

  localparam int unsigned MIN_PER_DAY = 1440;
  localparam int unsigned MIN_W       = 11;
  localparam int unsigned TGT_W       = 12;
  localparam int unsigned CNT_W       = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZED = 2'd3
  } alarm_state_e;

  // Minute addition with a single wrap at midnight.
  function automatic logic [MIN_W-1:0] add_min_wrap(input logic [MIN_W-1:0] m,
                                                    input logic [TGT_W-1:0] inc);
    logic [TGT_W-1:0] sum;
    sum = TGT_W'(m) + inc;
    if (sum >= TGT_W'(MIN_PER_DAY)) begin
      sum = sum - TGT_W'(MIN_PER_DAY);
    end
    return MIN_W'(sum);
  endfunction

  function automatic logic min_valid(input logic [MIN_W-1:0] m);
    return m < MIN_W'(MIN_PER_DAY);
  endfunction

endpackage

// File: rtl/alarm_edge_det.sv
// Rising-edge detector for a synchronized button level; a held level is one press.
module alarm_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_c
);

  logic prev_q, prev_d;

  always_comb begin
    prev_d = din;
    rise_c = din & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm-event controller: fires on the minute match and sequences
// ring / snooze / stop / timeout, driving buzzer and status outputs.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN     = 5,
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned MAX_SNOOZE     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_sec,
  input  logic [MIN_W-1:0] cur_min,
  input  logic [MIN_W-1:0] alarm_min,
  input  logic             alarm_en,
  input  logic             snooze_btn,
  input  logic             stop_btn,
  output logic             ring,
  output logic             buzz,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] snooze_cnt,
  output logic             missed
);

  localparam int unsigned SEC_W = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1;

  alarm_state_e     state_q, state_d;
  logic             ring_q, ring_d;
  logic             buzz_q, buzz_d;
  logic [CNT_W-1:0] snooze_cnt_q, snooze_cnt_d;
  logic             missed_q, missed_d;
  logic [SEC_W-1:0] ring_sec_q, ring_sec_d;
  logic [MIN_W-1:0] snooze_tgt_q, snooze_tgt_d;
  logic             match_a_q, match_a_d;
  logic             match_s_q, match_s_d;

  logic snooze_rise_c, stop_rise_c;
  logic trig_a, trig_s, can_snooze, timeout, go_snooze, go_ring;

  alarm_edge_det u_snooze_edge (
    .clk    (clk),
    .rst    (rst),
    .din    (snooze_btn),
    .rise_c (snooze_rise_c)
  );

  alarm_edge_det u_stop_edge (
    .clk    (clk),
    .rst    (rst),
    .din    (stop_btn),
    .rise_c (stop_rise_c)
  );

  // Next-state and output logic; only rising match edges trigger.
  always_comb begin
    state_d      = state_q;
    buzz_d       = buzz_q;
    snooze_cnt_d = snooze_cnt_q;
    missed_d     = missed_q;
    ring_sec_d   = ring_sec_q;
    snooze_tgt_d = snooze_tgt_q;
    go_snooze    = 1'b0;
    go_ring      = 1'b0;

    match_a_d  = (cur_min == alarm_min) && min_valid(cur_min);
    match_s_d  = (cur_min == snooze_tgt_q) && min_valid(cur_min);
    trig_a     = match_a_d & ~match_a_q;
    trig_s     = match_s_d & ~match_s_q;
    can_snooze = snooze_cnt_q < CNT_W'(MAX_SNOOZE);
    timeout    = tick_sec && (ring_sec_q == SEC_W'(RING_TIMEOUT_S - 1));

    if (!alarm_en) begin
      state_d      = ST_IDLE;
      buzz_d       = 1'b0;
      snooze_cnt_d = '0;
      missed_d     = 1'b0;
      ring_sec_d   = '0;
    end else begin
      if (stop_rise_c) missed_d = 1'b0;
      unique case (state_q)
        ST_IDLE: state_d = ST_ARMED;
        ST_ARMED: begin
          if (trig_a) go_ring = 1'b1;
        end
        ST_RINGING: begin
          if (stop_rise_c) begin
            state_d      = ST_ARMED;
            snooze_cnt_d = '0;
            buzz_d       = 1'b0;
            ring_sec_d   = '0;
          end else if (snooze_rise_c && can_snooze) begin
            go_snooze = 1'b1;
          end else if (timeout) begin
            if (can_snooze) begin
              go_snooze = 1'b1;
            end else begin
              state_d      = ST_ARMED;
              snooze_cnt_d = '0;
              missed_d     = 1'b1;
              buzz_d       = 1'b0;
              ring_sec_d   = '0;
            end
          end else if (tick_sec) begin
            buzz_d     = ~buzz_q;
            ring_sec_d = ring_sec_q + SEC_W'(1);
          end
        end
        ST_SNOOZED: begin
          if (stop_rise_c) begin
            state_d      = ST_ARMED;
            snooze_cnt_d = '0;
          end else if (trig_s) begin
            go_ring = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (go_snooze) begin
        state_d      = ST_SNOOZED;
        snooze_cnt_d = snooze_cnt_q + CNT_W'(1);
        snooze_tgt_d = add_min_wrap(cur_min, TGT_W'(SNOOZE_MIN));
        buzz_d       = 1'b0;
        ring_sec_d   = '0;
      end
      if (go_ring) begin
        state_d    = ST_RINGING;
        buzz_d     = 1'b1;
        ring_sec_d = '0;
      end
    end

    ring_d = (state_d == ST_RINGING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ring_q       <= 1'b0;
      buzz_q       <= 1'b0;
      snooze_cnt_q <= '0;
      missed_q     <= 1'b0;
      ring_sec_q   <= '0;
      snooze_tgt_q <= '0;
      match_a_q    <= 1'b0;
      match_s_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ring_q       <= ring_d;
      buzz_q       <= buzz_d;
      snooze_cnt_q <= snooze_cnt_d;
      missed_q     <= missed_d;
      ring_sec_q   <= ring_sec_d;
      snooze_tgt_q <= snooze_tgt_d;
      match_a_q    <= match_a_d;
      match_s_q    <= match_s_d;
    end
  end

  assign ring       = ring_q;
  assign buzz       = buzz_q;
  assign state_o    = state_q;
  assign snooze_cnt = snooze_cnt_q;
  assign missed     = missed_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: vector table, corner-case sequences, random vs. model.
module tb_alarm_sequencer;

  localparam int T_OUT = 4;

  logic        clk = 1'b0;
  logic        rst, tick_sec, alarm_en, snooze_btn, stop_btn;
  logic [10:0] cur_min, alarm_min;
  logic        ring, buzz, missed;
  logic [1:0]  state_o, snooze_cnt;

  int tests = 0;
  int fails = 0;

  alarm_sequencer #(.SNOOZE_MIN(5), .RING_TIMEOUT_S(T_OUT), .MAX_SNOOZE(3)) dut (
    .clk(clk), .rst(rst), .tick_sec(tick_sec), .cur_min(cur_min),
    .alarm_min(alarm_min), .alarm_en(alarm_en), .snooze_btn(snooze_btn),
    .stop_btn(stop_btn), .ring(ring), .buzz(buzz), .state_o(state_o),
    .snooze_cnt(snooze_cnt), .missed(missed)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic en; int cur; int alm; logic tick; logic snz; logic stp;
    int st; logic ring; logic buzz; int cnt; logic missed;
  } vec_t;

  function automatic vec_t mk(logic en, int cur, int alm, logic tick, logic snz, logic stp,
                              int st, logic rg, logic bz, int cnt, logic ms);
    vec_t v;
    v.en = en; v.cur = cur; v.alm = alm; v.tick = tick; v.snz = snz; v.stp = stp;
    v.st = st; v.ring = rg; v.buzz = bz; v.cnt = cnt; v.missed = ms;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, int st, int rg, int bz, int cnt, int ms);
    chk({tag, ".state"}, int'(state_o), st);
    chk({tag, ".ring"}, int'(ring), rg);
    chk({tag, ".buzz"}, int'(buzz), bz);
    chk({tag, ".snooze_cnt"}, int'(snooze_cnt), cnt);
    chk({tag, ".missed"}, int'(missed), ms);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick_sec = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Behavioural reference: states 0 idle, 1 armed, 2 ringing, 3 snoozed.
  int m_st, m_cnt, m_sec, m_tgt;
  bit m_buzz, m_missed, m_pa, m_ps, m_psnz, m_pstp;

  task automatic model_step(bit r, bit en, int cur, int alm, bit tk, bit snz, bit stp);
    bit ma, ms, ea, es, press_snz, press_stp, do_snooze;
    if (r) begin
      m_st = 0; m_cnt = 0; m_sec = 0; m_tgt = 0;
      m_buzz = 0; m_missed = 0; m_pa = 0; m_ps = 0; m_psnz = 0; m_pstp = 0;
      return;
    end
    ma = (cur < 1440) && (cur == alm);
    ms = (cur < 1440) && (cur == m_tgt);
    ea = ma && !m_pa;  es = ms && !m_ps;
    press_snz = snz && !m_psnz;  press_stp = stp && !m_pstp;
    m_pa = ma; m_ps = ms; m_psnz = snz; m_pstp = stp;
    do_snooze = 0;
    if (!en) begin
      m_st = 0; m_cnt = 0; m_sec = 0; m_buzz = 0; m_missed = 0;
      return;
    end
    if (press_stp) m_missed = 0;
    case (m_st)
      0: m_st = 1;
      1: if (ea) begin m_st = 2; m_sec = 0; m_buzz = 1; end
      2: begin
        if (press_stp) begin
          m_st = 1; m_cnt = 0; m_buzz = 0; m_sec = 0;
        end else if (press_snz && m_cnt < 3) begin
          do_snooze = 1;
        end else if (tk && m_sec == T_OUT - 1) begin
          if (m_cnt < 3) do_snooze = 1;
          else begin m_st = 1; m_cnt = 0; m_missed = 1; m_buzz = 0; m_sec = 0; end
        end else if (tk) begin
          m_buzz = !m_buzz; m_sec++;
        end
        if (do_snooze) begin
          m_st = 3; m_cnt++; m_tgt = (cur + 5) % 1440; m_buzz = 0; m_sec = 0;
        end
      end
      default: begin
        if (press_stp) begin m_st = 1; m_cnt = 0; end
        else if (es) begin m_st = 2; m_sec = 0; m_buzz = 1; end
      end
    endcase
  endtask

  vec_t vecs[$];
  int   cur_v;
  int   pick;

  initial begin
    rst = 1'b1; tick_sec = 1'b0; alarm_en = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
    cur_min = 11'd0; alarm_min = 11'd420;
    step(); step();
    chk_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Table: arm, ring, stop, re-trigger, wrap snooze, simultaneous buttons, out of range
    //             en cur  alm  tk snz stp  st rg bz cnt ms
    vecs.push_back(mk(1, 419, 420, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 419, 420, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 420, 420, 0, 0, 0, 2, 1, 1, 0, 0));
    vecs.push_back(mk(1, 420, 420, 1, 0, 0, 2, 1, 0, 0, 0));
    vecs.push_back(mk(1, 420, 420, 1, 0, 0, 2, 1, 1, 0, 0));
    vecs.push_back(mk(1, 420, 420, 0, 0, 0, 2, 1, 1, 0, 0));
    vecs.push_back(mk(1, 420, 420, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 420, 420, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 420, 420, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 421, 420, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 420, 420, 0, 0, 0, 2, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1438, 420, 0, 1, 0, 3, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1439, 420, 0, 1, 0, 3, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 420, 0, 0, 0, 3, 0, 0, 1, 0));
    vecs.push_back(mk(1, 3, 420, 0, 0, 0, 2, 1, 1, 1, 0));
    vecs.push_back(mk(1, 3, 420, 0, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 100, 100, 0, 0, 0, 2, 1, 1, 0, 0));
    vecs.push_back(mk(1, 100, 100, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2000, 2000, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2000, 2000, 0, 0, 0, 1, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      alarm_en = vecs[i].en; cur_min = 11'(vecs[i].cur); alarm_min = 11'(vecs[i].alm);
      tick_sec = vecs[i].tick; snooze_btn = vecs[i].snz; stop_btn = vecs[i].stp;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ring, vecs[i].buzz,
              vecs[i].cnt, vecs[i].missed);
    end

    // Timeouts: three auto-snoozes, then abandon with missed set
    do_reset();
    alarm_en = 1'b1; alarm_min = 11'd500; cur_min = 11'd499;
    step();
    cur_v = 500; cur_min = 11'(cur_v);
    step();
    chk_all("to.start", 2, 1, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      for (int t = 0; t < T_OUT; t++) begin
        tick_sec = 1'b1; step();
        tick_sec = 1'b0; step();
        if (t == T_OUT - 2) chk($sformatf("to%0d.before", k), int'(state_o), 2);
      end
      if (k < 3) begin
        chk_all($sformatf("to%0d.snoozed", k), 3, 0, 0, k + 1, 0);
        cur_v += 5; cur_min = 11'(cur_v);
        step();
        chk_all($sformatf("to%0d.rering", k), 2, 1, 1, k + 1, 0);
      end else begin
        chk_all("to.abandon", 1, 0, 0, 0, 1);
      end
    end
    stop_btn = 1'b1; step();
    chk_all("to.stop_clears", 1, 0, 0, 0, 0);
    stop_btn = 1'b0; step();

    // Drop enable while snoozed twice, then reset while ringing
    do_reset();
    alarm_en = 1'b1; alarm_min = 11'd10; cur_min = 11'd9; step();
    cur_min = 11'd10; step();
    snooze_btn = 1'b1; step();
    snooze_btn = 1'b0; cur_min = 11'd15; step();
    chk_all("en.rering", 2, 1, 1, 1, 0);
    snooze_btn = 1'b1; step();
    snooze_btn = 1'b0; step();
    chk_all("en.snoozed2", 3, 0, 0, 2, 0);
    alarm_en = 1'b0; step();
    chk_all("en.drop", 0, 0, 0, 0, 0);
    alarm_en = 1'b1; step();
    alarm_min = 11'd20; cur_min = 11'd19; step();
    cur_min = 11'd20; step();
    chk_all("rst.ringing", 2, 1, 1, 0, 0);
    rst = 1'b1; step();
    chk_all("rst.mid", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Random stimulus against the model
    rst = 1'b1; model_step(1, 0, 0, 0, 0, 0, 0); step(); rst = 1'b0;
    alarm_en = 1'b1; alarm_min = 11'd50; cur_min = 11'd49;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      alarm_en = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 299) == 0) begin
        pick = $urandom_range(0, 3);
        alarm_min = (pick == 0) ? 11'd1500 : (pick == 1) ? 11'd1439 : 11'd50;
      end
      if ($urandom_range(0, 5) == 0) begin
        pick = $urandom_range(0, 5);
        case (pick)
          0: cur_min = alarm_min;
          1: cur_min = alarm_min - 11'd1;
          2: cur_min = 11'(m_tgt);
          3: cur_min = 11'(m_tgt) + 11'd1;
          4: cur_min = 11'(1438 + $urandom_range(0, 1));
          default: cur_min = 11'($urandom_range(0, 2047));
        endcase
      end
      tick_sec = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) snooze_btn = ~snooze_btn;
      if ($urandom_range(0, 39) == 0) stop_btn = ~stop_btn;
      model_step(rst, alarm_en, int'(cur_min), int'(alarm_min), tick_sec, snooze_btn, stop_btn);
      step();
      chk($sformatf("rnd%0d.outs", c),
          int'({state_o, ring, buzz, snooze_cnt, missed}),
          int'({2'(m_st), (m_st == 2), m_buzz, 2'(m_cnt), m_missed}));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
